// File: rtl/serial_addsub.sv
// Bit-serial two's-complement add/subtract: one full-adder cell, one bit per cycle, NZCV flags.
// Latency: start accepted at edge k -> done pulses in the cycle after edge k+WIDTH.
// Backpressure: start is ignored while busy; a start during the done cycle is accepted back-to-back.
module serial_addsub #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic             r_carry;
    logic [CW-1:0]    r_count;
    logic             r_zacc;
    logic [WIDTH-1:0] r_result;
    logic             r_neg;
    logic             r_zero;
    logic             r_cout;
    logic             r_ovf;

    logic w_s;
    logic w_c;
    logic w_accept;
    logic w_run;
    logic w_last;

    // The single full-adder cell, fed from the low bits of the operand shifters.
    assign w_s      = r_opa[0] ^ r_opb[0] ^ r_carry;
    assign w_c      = (r_opa[0] & r_opb[0]) | (r_opa[0] & r_carry) | (r_opb[0] & r_carry);
    assign w_run    = (r_state == S_RUN);
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_count == CW'(WIDTH - 1));

    // Control FSM: IDLE/DONE accept a start, RUN lasts exactly WIDTH cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) r_state <= S_RUN;
                S_RUN:   if (w_last) r_state <= S_DONE;
                S_DONE:  r_state <= start ? S_RUN : S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Datapath: load operands on accept (subtract = A + ~B + 1), then shift one bit per RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
            r_zacc   <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_opa   <= A;
            r_opb   <= sub ? ~B : B;
            r_carry <= sub;
            r_count <= '0;
            r_zacc  <= 1'b0;
        end else if (w_run) begin
            r_opa    <= {1'b0, r_opa[WIDTH-1:1]};
            r_opb    <= {1'b0, r_opb[WIDTH-1:1]};
            r_result <= {w_s, r_result[WIDTH-1:1]};
            r_carry  <= w_c;
            r_zacc   <= r_zacc | w_s;
            r_count  <= r_count + CW'(1);
        end
    end

    // Flags latch on the MSB cycle; r_carry is then the carry into the MSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_neg  <= 1'b0;
            r_zero <= 1'b0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_run && w_last) begin
            r_neg  <= w_s;
            r_zero <= ~(r_zacc | w_s);
            r_cout <= w_c;
            r_ovf  <= r_carry ^ w_c;
        end
    end

    assign busy      = w_run;
    assign done      = (r_state == S_DONE);
    assign result    = r_result;
    assign negative  = r_neg;
    assign zero      = r_zero;
    assign carry_out = r_cout;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: WIDTH=64 vector table plus corner sequences, and a WIDTH=4 exhaustive sweep.
// Expected results are queued when a start is driven and compared when done pulses.
// Latency is checked against the cycle at which each start was driven.
module tb_serial_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] res;
        logic [3:0]  nzcv;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        s;
        logic [63:0] res;
        logic [3:0]  nzcv;
    } vec_t;

    exp_t q64[$];
    exp_t q4[$];

    // 64-bit instance
    logic        reset64, start64, sub64;
    logic [63:0] A64, B64, result64;
    logic        busy64, done64, n64, z64, c64, v64;

    // 4-bit instance
    logic        reset4, start4, sub4;
    logic [3:0]  A4, B4, result4;
    logic        busy4, done4, n4, z4, c4, v4;

    serial_addsub #(.WIDTH(64)) u64 (
        .clk(clk), .reset(reset64), .start(start64), .sub(sub64), .A(A64), .B(B64),
        .busy(busy64), .done(done64), .result(result64), .negative(n64), .zero(z64),
        .carry_out(c64), .overflow(v64)
    );

    serial_addsub #(.WIDTH(4)) u4 (
        .clk(clk), .reset(reset4), .start(start4), .sub(sub4), .A(A4), .B(B4),
        .busy(busy4), .done(done4), .result(result4), .negative(n4), .zero(z4),
        .carry_out(c4), .overflow(v4)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Scoreboard pop for the 64-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (busy64 && done64) chk("busy_done_overlap64", 64'd1, 64'd0);
        if (done64) begin
            if (q64.size() == 0) begin
                chk("unexpected_done64", 64'd1, 64'd0);
            end else begin
                e = q64.pop_front();
                chk("result64", result64, e.res);
                chk("nzcv64", {60'd0, n64, z64, c64, v64}, {60'd0, e.nzcv});
                chk("latency64", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Scoreboard pop for the 4-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (done4) begin
            if (q4.size() == 0) begin
                chk("unexpected_done4", 64'd1, 64'd0);
            end else begin
                e = q4.pop_front();
                chk("result4", {60'd0, result4}, e.res);
                chk("nzcv4", {60'd0, n4, z4, c4, v4}, {60'd0, e.nzcv});
                chk("latency4", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic do_op64(input vec_t v, input bit push);
        exp_t e;
        int t = 0;
        while (busy64 && t < 200) begin @(negedge clk); t++; end
        if (busy64) chk("wait_idle64_timeout", 64'd1, 64'd0);
        A64 = v.a; B64 = v.b; sub64 = v.s; start64 = 1'b1;
        if (push) begin
            e.res = v.res; e.nzcv = v.nzcv; e.cyc = cyc + 1 + 64;
            q64.push_back(e);
        end
        @(posedge clk); #1;
        start64 = 1'b0;
    endtask

    task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input logic s);
        exp_t e;
        logic [3:0] bb;
        logic [4:0] sum;
        int t = 0;
        while (busy4 && t < 50) begin @(negedge clk); t++; end
        if (busy4) chk("wait_idle4_timeout", 64'd1, 64'd0);
        bb  = s ? ~b : b;
        sum = {1'b0, a} + {1'b0, bb} + {4'd0, s};
        e.res  = {60'd0, sum[3:0]};
        e.nzcv = {sum[3], sum[3:0] == 4'd0, sum[4], (a[3] == bb[3]) && (sum[3] != a[3])};
        e.cyc  = cyc + 1 + 4;
        q4.push_back(e);
        A4 = a; B4 = b; sub4 = s; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
    endtask

    task automatic drain(input int which);
        int t = 0;
        if (which == 64) begin
            while ((q64.size() != 0 || busy64) && t < 500) begin @(negedge clk); t++; end
            if (q64.size() != 0) chk("drain64_timeout", 64'(q64.size()), 64'd0);
        end else begin
            while ((q4.size() != 0 || busy4) && t < 500) begin @(negedge clk); t++; end
            if (q4.size() != 0) chk("drain4_timeout", 64'(q4.size()), 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    vec_t vt[7];
    vec_t vx;

    initial begin
        int t;
        int dcount;
        vt[0] = '{64'd1, 64'd1, 1'b0, 64'd2, 4'b0000};
        vt[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b1001};
        vt[2] = '{64'd5, 64'd5, 1'b1, 64'd0, 4'b0110};
        vt[3] = '{64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000};
        vt[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b0110};
        vt[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
        vt[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 4'b0111};

        reset64 = 1'b1; start64 = 1'b0; sub64 = 1'b0; A64 = '0; B64 = '0;
        reset4  = 1'b1; start4  = 1'b0; sub4  = 1'b0; A4  = '0; B4  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset64 = 1'b0; reset4 = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_busy", {63'd0, busy64}, 64'd0);
        chk("rst_done", {63'd0, done64}, 64'd0);
        chk("rst_result", result64, 64'd0);
        chk("rst_flags", {60'd0, n64, z64, c64, v64}, 64'd0);

        // Vector table
        for (int i = 0; i < 7; i++) begin
            do_op64(vt[i], 1'b1);
            drain(64);
        end

        // Start pulse mid-run (count 10) is ignored
        do_op64(vt[1], 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        A64 = 64'hDEAD_BEEF_0000_1234; B64 = 64'h1111; sub64 = 1'b1; start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        drain(64);

        // Back-to-back: start during the done cycle
        do_op64(vt[0], 1'b1);
        t = 0;
        while (!done64 && t < 200) begin @(negedge clk); t++; end
        chk("b2b_done_seen", {63'd0, done64}, 64'd1);
        do_op64(vt[5], 1'b1);
        chk("b2b_busy_after_accept", {63'd0, busy64}, 64'd1);
        drain(64);

        // Reset at count 30 aborts the op
        do_op64(vt[1], 1'b0);
        repeat (30) @(posedge clk);
        @(negedge clk);
        reset64 = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", {63'd0, busy64}, 64'd0);
        chk("abort_done", {63'd0, done64}, 64'd0);
        chk("abort_result", result64, 64'd0);
        chk("abort_flags", {60'd0, n64, z64, c64, v64}, 64'd0);
        @(negedge clk);
        reset64 = 1'b0;
        dcount = 0;
        repeat (100) begin @(negedge clk); if (done64) dcount++; end
        chk("abort_no_done", 64'(dcount), 64'd0);

        // Reset and start on the same edge: reset wins
        @(negedge clk);
        vx = vt[0];
        reset64 = 1'b1; A64 = vx.a; B64 = vx.b; sub64 = 1'b0; start64 = 1'b1;
        @(posedge clk); #1;
        chk("rst_start_busy", {63'd0, busy64}, 64'd0);
        @(negedge clk);
        start64 = 1'b0; reset64 = 1'b0;
        @(negedge clk);
        chk("rst_start_busy_after", {63'd0, busy64}, 64'd0);

        // WIDTH=4 exhaustive sweep in shuffled operand order
        for (int i = 0; i < 512; i++) begin
            int k;
            k = (i * 37 + 11) % 512;
            do_op4(k[3:0], k[7:4], k[8]);
        end
        drain(4);

        drain(64);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
